pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised successor to the team's 32-bit ripple-carry adder.
- WIDTH-bit add/subtract unit with carry-in, split into CHUNK-bit carry-skewed pipeline stages.
- Valid/ready handshake on both sides; a global stall is driven by downstream backpressure.
- Sits between operand registers and the datapath writeback, where a single-cycle WIDTH-bit ripple path misses timing.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- CHUNK, 8, bits added per pipeline stage. WIDTH must be a multiple of CHUNK; elaboration error otherwise.
- STAGES, WIDTH/CHUNK, derived (localparam). Number of pipeline stages, which equals latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow (a >= b unsigned).
- overflow  output  1  signed two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (asynchronous, any time): clear all stage valid bits and all data/carry registers. out_valid=0, sum=0, cout=0, overflow=0. Any in-flight beats are discarded. First accept is possible on the first clk edge after reset deasserts.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - adds chunk k of a and b_eff with the carry registered by stage k-1 (c0 for stage 0);
  - registers the chunk-k sum and its carry-out;
  - carries forward the not-yet-added upper chunks (skew registers);
  - carries forward the finished lower sum chunks (de-skew registers).
- Final stage also registers overflow from the MSB carry-in/carry-out of the top chunk.
- Each stage holds its own valid bit; bubbles propagate as valid=0 and carry no meaning.
- Latency: a beat accepted at edge N appears at the outputs with out_valid=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES. Throughput is 1 beat/cycle when not stalled.
- stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
- When stalled, every stage register holds, including bubbles. No bubble collapsing.
- Accept only when in_valid & in_ready. A beat is consumed downstream when out_valid & out_ready.
- Simultaneous accept and consume is allowed.
- Outputs hold stable while out_valid=1 and out_ready=0.
- sum, cout and overflow are don't-care while out_valid=0, but must not produce X after reset.
- Wrap-around: sum wraps modulo 2^WIDTH; the carry is reported only via cout.
- STAGES=1 (CHUNK=WIDTH) degenerates to a registered single-cycle adder with latency 1. The same handshake applies.
- No combinational path from a, b, or in_valid to any output.

Test Plan:
Bench uses WIDTH=32, CHUNK=8 (latency 4), out_ready=1 unless noted.
- Basic add: a=0x0000_0001, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0002, cout=0, overflow=0.
- Full carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, overflow=0. Then a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, cout=0, overflow=1.
- Subtract: a=5, b=3, sub=1 -> sum=2, cout=1. Then a=3, b=5, sub=1 -> sum=0xFFFF_FFFE, cout=0, overflow=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, overflow=1.
- Streaming: one beat per cycle for 32 cycles with a=1<<i, b=3<<i (i=0..31) -> 32 consecutive out_valid beats in issue order, each equal to {1'b0,a}+{1'b0,b}. cin is ignored in sub mode (sub=1, cin=1, a=b=7 -> sum=0).
- Backpressure: issue 6 beats, hold out_ready=0 from the cycle the first result appears for 5 cycles -> in_ready=0 during the stall, outputs frozen on beat 0, no beat lost or duplicated; all 6 results drain in order after out_ready=1.
- Reset mid-operation: assert reset asynchronously (between edges) with 3 beats in flight -> out_valid drops immediately, sum/cout/overflow=0; after release, a fresh beat a=0x10, b=0x20 returns sum=0x30 with no stale beats emitted.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract unit with carry-in, split into
// CHUNK-bit carry-skewed pipeline stages (latency STAGES = WIDTH/CHUNK).
// Valid/ready handshake on both sides; downstream backpressure stalls
// every stage at once, bubbles included.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  // Chunks must tile the operand exactly.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  // Per-stage inputs (from the previous stage, or operand conditioning).
  // x carries finished sum chunks below the current chunk and the
  // not-yet-added operand A chunks above it; y carries the conditioned B.
  logic [WIDTH-1:0] x_in  [STAGES];
  logic [WIDTH-1:0] y_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];

  // Per-stage registered outputs.
  logic [WIDTH-1:0] x_out [STAGES];
  logic [WIDTH-1:0] y_out [STAGES];
  logic             c_out [STAGES];
  logic             v_out [STAGES];

  logic             overflow_reg;
  logic             stall;

  // Global stall: the result beat at the output is not being taken.
  assign stall    = v_out[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic             c_reg;
    logic             v_reg;

    if (gi == 0) begin : g_first
      // Subtraction is a + ~b + 1; carry-in is ignored in that mode.
      assign x_in[gi] = a;
      assign y_in[gi] = sub ? ~b : b;
      assign c_in[gi] = sub | cin;
      assign v_in[gi] = in_valid;
    end else begin : g_chain
      assign x_in[gi] = x_out[gi-1];
      assign y_in[gi] = y_out[gi-1];
      assign c_in[gi] = c_out[gi-1];
      assign v_in[gi] = v_out[gi-1];
    end

    assign chunk_sum = {1'b0, x_in[gi][LO +: CHUNK]}
                     + {1'b0, y_in[gi][LO +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_in[gi]};

    // Replace this stage's operand chunk with its finished sum chunk.
    always_comb begin
      x_next               = x_in[gi];
      x_next[LO +: CHUNK]  = chunk_sum[CHUNK-1:0];
    end

    // Stage register: advances only when the pipeline is not stalled.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_reg <= 1'b0;
        x_reg <= '0;
        y_reg <= '0;
        c_reg <= 1'b0;
      end else if (!stall) begin
        v_reg <= v_in[gi];
        x_reg <= x_next;
        y_reg <= y_in[gi];
        c_reg <= chunk_sum[CHUNK];
      end
    end

    assign x_out[gi] = x_reg;
    assign y_out[gi] = y_reg;
    assign c_out[gi] = c_reg;
    assign v_out[gi] = v_reg;

    if (gi == STAGES - 1) begin : g_last
      // Signed overflow: carry into the MSB (recovered from the MSB sum
      // bit and its operands) XOR carry out of the MSB.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          overflow_reg <= 1'b0;
        end else if (!stall) begin
          overflow_reg <= chunk_sum[CHUNK]
                        ^ (x_in[gi][WIDTH-1] ^ y_in[gi][WIDTH-1] ^ chunk_sum[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = v_out[STAGES-1];
  assign sum       = x_out[STAGES-1];
  assign cout      = c_out[STAGES-1];
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed + random stimulus against a scoreboard
// model of a STAGES-deep handshake pipeline with arithmetic reference.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int C = 8;
  localparam int S = W / C;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t mslot  [S];
  bit   mvalid [S];
  res_t next_exp;

  int total    = 0;
  int bad      = 0;
  int issued   = 0;
  int consumed = 0;

  // Directed table: a, b, cin, sub -> sum, cout, overflow
  logic [W-1:0] ta [7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd3, 32'h8000_0000, 32'd7};
  logic [W-1:0] tb [7] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'd3, 32'd5, 32'h0000_0001, 32'd7};
  bit           tc [7] = '{0, 1, 0, 0, 0, 0, 1};
  bit           tsb[7] = '{0, 0, 0, 1, 1, 1, 1};
  logic [W-1:0] ts [7] = '{32'h0000_0002, 32'h0000_0000, 32'h8000_0000, 32'd2, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd0};
  bit           tco[7] = '{0, 1, 0, 1, 0, 1, 1};
  bit           tov[7] = '{0, 0, 1, 0, 0, 1, 0};

  // Arithmetic reference: unsigned sum/difference and signed overflow rule.
  function automatic res_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic sb);
    res_t     r;
    logic [W:0] full;
    if (sb) begin
      r.s = x - y;
      r.c = (x >= y);
      r.o = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.o  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    next_exp = ref_model(x, y, ci, sb);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
  endtask

  // One clock: check in_ready, advance the model at the edge, check outputs.
  task automatic cycle(output bit took);
    bit stall_m;
    #1;
    stall_m = mvalid[S-1] && !out_ready;
    chk("in_ready", W'(in_ready), W'(!stall_m));
    took = in_valid && !stall_m;
    @(posedge clk);
    if (mvalid[S-1] && out_ready) consumed++;
    if (!stall_m) begin
      for (int k = S - 1; k > 0; k--) begin
        mvalid[k] = mvalid[k-1];
        mslot[k]  = mslot[k-1];
      end
      mvalid[0] = in_valid;
      mslot[0]  = next_exp;
      if (in_valid) issued++;
    end
    @(negedge clk);
    chk("out_valid", W'(out_valid), W'(mvalid[S-1]));
    if (mvalid[S-1]) begin
      chk("sum", sum, mslot[S-1].s);
      chk("cout", W'(cout), W'(mslot[S-1].c));
      chk("overflow", W'(overflow), W'(mslot[S-1].o));
    end
  endtask

  task automatic drain();
    bit t;
    out_ready = 1'b1;
    idle();
    repeat (S + 2) cycle(t);
  endtask

  initial begin
    bit           took;
    bit           pend;
    bit           seen;
    int           hold;
    int           idx;
    logic [W-1:0] bpa [6];
    logic [W-1:0] bpb [6];
    bit           bps [6];

    reset     = 1'b1;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    in_valid  = 1'b0;
    next_exp  = '0;
    for (int k = 0; k < S; k++) begin
      mvalid[k] = 1'b0;
      mslot[k]  = '0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), '0);
    chk("rst_overflow", W'(overflow), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);
    reset = 1'b0;

    // Directed table, back to back, with hand-computed expectations
    for (int i = 0; i < 7; i++) begin
      drive(ta[i], tb[i], tc[i], tsb[i]);
      next_exp.s = ts[i];
      next_exp.c = tco[i];
      next_exp.o = tov[i];
      cycle(took);
    end
    drain();

    // Streaming: one beat per cycle for 32 cycles
    for (int i = 0; i < 32; i++) begin
      drive(W'(1) << i, W'(3) << i, 1'b0, 1'b0);
      cycle(took);
    end
    drain();
    chk("stream_count", W'(consumed), W'(issued));

    // Backpressure: 6 beats, 5-cycle stall starting when the first result shows
    for (int i = 0; i < 6; i++) begin
      bpa[i] = $urandom;
      bpb[i] = $urandom;
      bps[i] = 1'($urandom_range(0, 1));
    end
    idx  = 0;
    hold = 0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!seen && mvalid[S-1]) begin
        seen = 1'b1;
        hold = 5;
      end
      out_ready = !(hold > 0);
      if (hold > 0) hold--;
      if (idx < 6) drive(bpa[idx], bpb[idx], 1'b0, bps[idx]);
      else idle();
      cycle(took);
      if (took) idx++;
    end
    chk("bp_issued", W'(idx), W'(6));
    drain();
    chk("bp_count", W'(consumed), W'(issued));

    // Random traffic with random backpressure
    pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          pend = 1'b1;
        end else begin
          idle();
        end
      end
      cycle(took);
      if (took) pend = 1'b0;
    end
    drain();
    chk("rand_count", W'(consumed), W'(issued));

    // Reset mid-operation with beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(W'(100 + i), W'(i), 1'b0, 1'b0);
      cycle(took);
    end
    idle();
    cycle(took);
    chk("pre_rst_valid", W'(out_valid), W'(1'b1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", W'(cout), '0);
    chk("midrst_overflow", W'(overflow), '0);
    for (int k = 0; k < S; k++) mvalid[k] = 1'b0;
    issued   = 0;
    consumed = 0;
    @(negedge clk);
    reset = 1'b0;
    drive(32'h10, 32'h20, 1'b0, 1'b0);
    next_exp.s = 32'h30;
    next_exp.c = 1'b0;
    next_exp.o = 1'b0;
    cycle(took);
    drain();
    chk("fresh_count", W'(consumed), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
